// File: rtl/systolic_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : systolic_seq_ctrl
// Purpose  : Sequencer for an N x M output-stationary systolic MAC array that
//            computes C(NxM) = A(NxK) x B(KxM). It produces the skewed
//            operand-buffer read enables, the array-wide accumulate strobe and
//            the C write-back request.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk         in   1  rising-edge clock
//   rst         in   1  asynchronous, active-low reset
//   finished    in   1  acknowledge that C write-back is complete
//   A_start_en  out  N  bit i = read enable / mux select for A row i
//   B_start_en  out  M  bit j = read enable / mux select for B column j
//   load        out  1  MAC accumulate enable, common to all PEs
//   C_write_en  out  1  request to write the C results out of the array
// ----------------------------------------------------------------------------
// Sequence: IDLE (1 cycle) -> COMPUTE (K+N+M-2 cycles) -> WRITE (until
// finished) -> DONE (until reset). Every output is a decode of the state
// register and the cycle counter only, so nothing combinational leads from
// finished to an output.
// ============================================================================
module systolic_seq_ctrl #(
    parameter int N  = 3,
    parameter int M  = 3,
    parameter int K  = 3,
    parameter int CW = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         finished,
    output logic [N-1:0] A_start_en,
    output logic [M-1:0] B_start_en,
    output logic         load,
    output logic         C_write_en
);

    // COMPUTE length: the last product enters PE(N-1,M-1) at cnt = N+M+K-3.
    localparam int            C_LEN  = K + N + M - 2;
    localparam logic [CW-1:0] C_LAST = CW'(C_LEN - 1);
    localparam logic [CW-1:0] C_ONE  = CW'(1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COMPUTE = 2'd1,
        ST_WRITE   = 2'd2,
        ST_DONE    = 2'd3
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [CW-1:0]   r_cnt;
    logic [CW-1:0]   w_cnt_nxt;

    // Per-row / per-column skew windows: row i (column j) reads its K operands
    // on cnt = i .. i+K-1 (j .. j+K-1), so each element meets its partner at
    // the PE after the one-register-per-hop forwarding in the grid.
    logic [N-1:0]    w_a_win;
    logic [M-1:0]    w_b_win;

    // ------------------------------------------------------------------------
    // State and counter register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // ------------------------------------------------------------------------
    // Skew window decode
    // ------------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_a_win
            localparam logic [CW-1:0] C_HI = CW'(gi + K - 1);
            if (gi == 0) begin : g_first
                // Lower bound of row 0 is cnt >= 0, always true.
                assign w_a_win[gi] = (r_cnt <= C_HI);
            end else begin : g_rest
                localparam logic [CW-1:0] C_LO = CW'(gi);
                assign w_a_win[gi] = (r_cnt >= C_LO) && (r_cnt <= C_HI);
            end
        end

        for (genvar gj = 0; gj < M; gj++) begin : g_b_win
            localparam logic [CW-1:0] C_HI = CW'(gj + K - 1);
            if (gj == 0) begin : g_first
                assign w_b_win[gj] = (r_cnt <= C_HI);
            end else begin : g_rest
                localparam logic [CW-1:0] C_LO = CW'(gj);
                assign w_b_win[gj] = (r_cnt >= C_LO) && (r_cnt <= C_HI);
            end
        end
    endgenerate

    // ------------------------------------------------------------------------
    // Next state, counter and Moore outputs
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_nxt = ST_IDLE;
        w_cnt_nxt   = '0;
        A_start_en  = '0;
        B_start_en  = '0;
        load        = 1'b0;
        C_write_en  = 1'b0;

        case (r_state)
            ST_IDLE: begin
                w_state_nxt = ST_COMPUTE;
            end

            ST_COMPUTE: begin
                A_start_en = w_a_win;
                B_start_en = w_b_win;
                load       = 1'b1;
                // ">=" rather than "==" so an out-of-range count still leaves
                // COMPUTE; the counter only advances below C_LAST and so
                // cannot wrap.
                if (r_cnt >= C_LAST) begin
                    w_state_nxt = ST_WRITE;
                end else begin
                    w_state_nxt = ST_COMPUTE;
                    w_cnt_nxt   = r_cnt + C_ONE;
                end
            end

            ST_WRITE: begin
                C_write_en  = 1'b1;
                w_state_nxt = finished ? ST_DONE : ST_WRITE;
            end

            ST_DONE: begin
                // Parked until the next reset pulse.
                w_state_nxt = ST_DONE;
            end

            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_systolic_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_systolic_seq_ctrl
// Purpose  : Self-checking bench for systolic_seq_ctrl. Two instances are
//            exercised: 3x3x3 (with a behavioural 3x3 PE grid attached) and
//            N=2, M=4, K=5. Expected per-cycle outputs are queued by the
//            stimulus process and compared by an independent monitor.
// Revision : 1.0 - initial release
// ============================================================================
module tb_systolic_seq_ctrl;

    logic       clk = 1'b0;
    logic       rst1, rst2, fin1, fin2;
    logic [2:0] a1, b1;
    logic       ld1, cw1;
    logic [1:0] a2;
    logic [3:0] b2;
    logic       ld2, cw2;
    logic       probe = 1'b0;

    always #5 clk = ~clk;

    systolic_seq_ctrl #(.N(3), .M(3), .K(3), .CW(8)) dut1 (
        .clk        (clk),
        .rst        (rst1),
        .finished   (fin1),
        .A_start_en (a1),
        .B_start_en (b1),
        .load       (ld1),
        .C_write_en (cw1)
    );

    systolic_seq_ctrl #(.N(2), .M(4), .K(5), .CW(8)) dut2 (
        .clk        (clk),
        .rst        (rst2),
        .finished   (fin2),
        .A_start_en (a2),
        .B_start_en (b2),
        .load       (ld2),
        .C_write_en (cw2)
    );

    // ------------------------------------------------------------------------
    // Hand-computed expectation tables
    // ------------------------------------------------------------------------
    logic [7:0] en3 [7] = '{8'b001, 8'b011, 8'b111, 8'b110, 8'b100, 8'b000, 8'b000};
    logic [7:0] a2t [9] = '{8'b01, 8'b11, 8'b11, 8'b11, 8'b11, 8'b10, 8'b00, 8'b00, 8'b00};
    logic [7:0] b2t [9] = '{8'b0001, 8'b0011, 8'b0111, 8'b1111, 8'b1111,
                            8'b1110, 8'b1100, 8'b1000, 8'b0000};
    // C = A x I = A, packed C[i][j] at bits (i*3+j)*8
    localparam logic [71:0] C_EXP = {8'd9, 8'd8, 8'd7, 8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1};

    // ------------------------------------------------------------------------
    // Behavioural 3x3 output-stationary PE grid driven by dut1
    // ------------------------------------------------------------------------
    int amat [3][3] = '{'{1, 2, 3}, '{4, 5, 6}, '{7, 8, 9}};
    int bmat [3][3] = '{'{1, 0, 0}, '{0, 1, 0}, '{0, 0, 1}};
    int ak [3];
    int bk [3];
    int ain [3][3];
    int bin [3][3];
    int ar  [3][3];
    int br  [3][3];
    int acc [3][3];

    always_comb begin
        for (int i = 0; i < 3; i++) begin
            for (int j = 0; j < 3; j++) begin
                ain[i][j] = 0;
                bin[i][j] = 0;
            end
        end
        for (int i = 0; i < 3; i++) begin
            ain[i][0] = (a1[i] && ak[i] < 3) ? amat[i][ak[i]] : 0;
            for (int j = 1; j < 3; j++) ain[i][j] = ar[i][j-1];
        end
        for (int j = 0; j < 3; j++) begin
            bin[0][j] = (b1[j] && bk[j] < 3) ? bmat[bk[j]][j] : 0;
            for (int i = 1; i < 3; i++) bin[i][j] = br[i-1][j];
        end
    end

    always @(posedge clk or negedge rst1) begin
        if (!rst1) begin
            for (int i = 0; i < 3; i++) begin
                ak[i] <= 0;
                bk[i] <= 0;
                for (int j = 0; j < 3; j++) begin
                    ar[i][j]  <= 0;
                    br[i][j]  <= 0;
                    acc[i][j] <= 0;
                end
            end
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (a1[i]) ak[i] <= ak[i] + 1;
                if (b1[i]) bk[i] <= bk[i] + 1;
                for (int j = 0; j < 3; j++) begin
                    ar[i][j] <= ain[i][j];
                    br[i][j] <= bin[i][j];
                    if (ld1) acc[i][j] <= acc[i][j] + ain[i][j] * bin[i][j];
                end
            end
        end
    end

    function automatic logic [71:0] pack_acc();
        logic [71:0] r;
        logic [31:0] v;
        r = '0;
        for (int i = 0; i < 3; i++) begin
            for (int j = 0; j < 3; j++) begin
                v = acc[i][j];
                r[(i*3+j)*8 +: 8] = v[7:0];
            end
        end
        return r;
    endfunction

    // ------------------------------------------------------------------------
    // Scoreboard
    // ------------------------------------------------------------------------
    typedef struct packed {
        logic [1:0]  dut;
        logic [7:0]  a;
        logic [7:0]  b;
        logic        ld;
        logic        cw;
        logic        chk_c;
        logic [71:0] c;
    } exp_t;

    exp_t  q  [$];
    string qn [$];
    int    checks = 0;
    int    errors = 0;

    task automatic push_exp(input int d, input logic [7:0] a, input logic [7:0] b,
                            input logic ld, input logic cw, input logic chk_c,
                            input string nm);
        exp_t e;
        e.dut   = 2'(d);
        e.a     = a;
        e.b     = b;
        e.ld    = ld;
        e.cw    = cw;
        e.chk_c = chk_c;
        e.c     = C_EXP;
        q.push_back(e);
        qn.push_back(nm);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expect outputs for the current cycle, then move to the next one.
    task automatic cyc(input int d, input logic [7:0] a, input logic [7:0] b,
                       input logic ld, input logic cw, input string nm);
        push_exp(d, a, b, ld, cw, 1'b0, nm);
        tick();
    endtask

    task automatic run3(input string tag);
        cyc(1, 8'd0, 8'd0, 1'b0, 1'b0, {tag, "_idle"});
        for (int c = 0; c < 7; c++)
            cyc(1, en3[c], en3[c], 1'b1, 1'b0, $sformatf("%s_compute%0d", tag, c));
    endtask

    // Monitor: compare on every falling edge, or immediately on a probe pulse.
    initial begin
        exp_t       e;
        string      n;
        logic [7:0] aa, bb;
        logic       ll, cc;
        logic [71:0] cact;
        forever begin
            @(negedge clk or posedge probe);
            if (q.size() > 0) begin
                e = q.pop_front();
                n = qn.pop_front();
                if (e.dut == 2'd1) begin
                    aa = {5'b0, a1}; bb = {5'b0, b1}; ll = ld1; cc = cw1;
                end else begin
                    aa = {6'b0, a2}; bb = {4'b0, b2}; ll = ld2; cc = cw2;
                end
                checks++;
                if (aa !== e.a || bb !== e.b || ll !== e.ld || cc !== e.cw) begin
                    errors++;
                    $display("FAIL %s: got A=%b B=%b load=%b cwe=%b, required A=%b B=%b load=%b cwe=%b",
                             n, aa, bb, ll, cc, e.a, e.b, e.ld, e.cw);
                end
                if (e.chk_c) begin
                    cact = pack_acc();
                    checks++;
                    if (cact !== e.c) begin
                        errors++;
                        $display("FAIL %s_cgrid: got C=%h, required C=%h", n, cact, e.c);
                    end
                end
            end
        end
    end

    // ------------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------------
    initial begin
        rst1 = 1'b1; rst2 = 1'b1; fin1 = 1'b0; fin2 = 1'b0;
        #2;
        rst1 = 1'b0; rst2 = 1'b0;
        tick();
        cyc(1, 8'd0, 8'd0, 1'b0, 1'b0, "reset1");
        cyc(2, 8'd0, 8'd0, 1'b0, 1'b0, "reset2");

        // Basic 3x3x3 run with grid integration, then finished pulse.
        rst1 = 1'b1;
        run3("t1");
        push_exp(1, 8'd0, 8'd0, 1'b0, 1'b1, 1'b1, "t1_write0");
        tick();
        cyc(1, 8'd0, 8'd0, 1'b0, 1'b1, "t1_write1");
        fin1 = 1'b1;
        cyc(1, 8'd0, 8'd0, 1'b0, 1'b1, "t1_write_fin");
        fin1 = 1'b0;
        for (int i = 0; i < 22; i++) cyc(1, 8'd0, 8'd0, 1'b0, 1'b0, "t1_done");

        // finished held high from reset release.
        rst1 = 1'b0; fin1 = 1'b1;
        cyc(1, 8'd0, 8'd0, 1'b0, 1'b0, "t3_reset");
        rst1 = 1'b1;
        run3("t3");
        cyc(1, 8'd0, 8'd0, 1'b0, 1'b1, "t3_write_once");
        for (int i = 0; i < 5; i++) cyc(1, 8'd0, 8'd0, 1'b0, 1'b0, "t3_done");
        fin1 = 1'b0;

        // Asynchronous abort at cnt=3.
        rst1 = 1'b0;
        cyc(1, 8'd0, 8'd0, 1'b0, 1'b0, "t4_reset");
        rst1 = 1'b1;
        cyc(1, 8'd0, 8'd0, 1'b0, 1'b0, "t4_idle");
        for (int c = 0; c < 3; c++)
            cyc(1, en3[c], en3[c], 1'b1, 1'b0, $sformatf("t4_compute%0d", c));
        push_exp(1, 8'b110, 8'b110, 1'b1, 1'b0, 1'b0, "t4_compute3");
        @(negedge clk);
        #1;
        rst1 = 1'b0;
        #1;
        push_exp(1, 8'd0, 8'd0, 1'b0, 1'b0, 1'b0, "t4_async_zero");
        probe = 1'b1;
        #1;
        probe = 1'b0;
        tick();
        cyc(1, 8'd0, 8'd0, 1'b0, 1'b0, "t4_held");
        rst1 = 1'b1;
        run3("t4_rerun");
        cyc(1, 8'd0, 8'd0, 1'b0, 1'b1, "t4_write");

        // N=2, M=4, K=5 instance.
        rst2 = 1'b1;
        cyc(2, 8'd0, 8'd0, 1'b0, 1'b0, "t5_idle");
        for (int c = 0; c < 9; c++)
            cyc(2, a2t[c], b2t[c], 1'b1, 1'b0, $sformatf("t5_compute%0d", c));
        cyc(2, 8'd0, 8'd0, 1'b0, 1'b1, "t5_write0");
        cyc(2, 8'd0, 8'd0, 1'b0, 1'b1, "t5_write1");

        tick();
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending entries, required 0", q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire

// File: doc/systolic_seq_ctrl.md
Name: systolic_seq_ctrl

Overview:
Sequencer for an N x M output-stationary systolic MAC array computing C(NxM) = A(NxK) x B(KxM).
- Generates skewed per-row read enables for A and per-column read enables for B.
- Generates the array-wide MAC accumulate strobe `load`.
- Generates the C write-back request.
- Sits between the operand buffers and the PE grid. The PE grid uses the same `clk`/`rst`; each PE accumulates A_in*B_in when `load`=1 and forwards A right, B down with one register stage.

Parameters:
- N, 3, number of array rows (A rows, C rows)
- M, 3, number of array columns (B columns, C columns)
- K, 3, inner dimension (A columns = B rows); K >= 1
- CW, 8, cycle-counter width; must hold K+N+M-2

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-low reset
- finished  input  1  external acknowledge that C write-back is complete
- A_start_en  output  N  bit i = read enable / mux select for A row i
- B_start_en  output  M  bit j = read enable / mux select for B column j
- load  output  1  MAC accumulate enable, common to all PEs
- C_write_en  output  1  request to write the C results out of the array

Behaviour:
- Single clock domain. `rst`=0 asynchronously forces state IDLE and cnt=0; all outputs go 0 immediately.
- All outputs are Moore decodes of the state register and cnt. No combinational path from `finished` to any output.
- State IDLE:
  - All outputs 0.
  - Next edge (`rst`=1) -> COMPUTE, cnt=0.
- State COMPUTE:
  - cnt increments by 1 each edge, starting from 0.
  - A_start_en[i] = 1 iff i <= cnt <= i+K-1.
  - B_start_en[j] = 1 iff j <= cnt <= j+K-1.
  - load = 1 for every COMPUTE cycle.
  - Length L = K+N+M-2 cycles (cnt 0..L-1). Last product reaches PE(N-1,M-1) at cnt = N+M+K-3.
  - At cnt = L-1: next edge -> WRITE, cnt=0.
  - `finished` is ignored in COMPUTE.
- State WRITE:
  - C_write_en=1; load=0; A_start_en=0; B_start_en=0.
  - Stays until `finished`=1 is sampled on an edge -> DONE.
  - If `finished` is already 1 on the first WRITE edge, C_write_en is high for exactly 1 cycle.
- State DONE:
  - All outputs 0; held until reset. A new computation requires a reset pulse.
- Reset asserted mid-COMPUTE or mid-WRITE aborts immediately. Outputs are 0 asynchronously. After release, the sequence restarts from IDLE.
- cnt saturates (never wraps) if ever outside the valid range. Illegal state encodings recover to IDLE.
- Skew rule: the number of cycles with A_start_en[i]=1 is exactly K for every i. Same for B_start_en[j].

Test Plan:
- Reset then release, N=M=K=3, `finished`=0:
  - IDLE for 1 cycle.
  - COMPUTE for 7 cycles with A_start_en (and B_start_en) = 001, 011, 111, 110, 100, 000, 000.
  - load=1 on all 7 cycles, then 0.
  - C_write_en rises on cycle 9 and stays 1.
- From WRITE, pulse `finished`=1 for one cycle -> C_write_en drops after that edge; state DONE; all outputs stay 0 for 20+ cycles.
- `finished` held 1 from reset release -> no effect during COMPUTE; C_write_en high for exactly 1 cycle; then DONE.
- Drive `rst`=0 at COMPUTE cnt=3 (A_start_en=110) -> all outputs 0 immediately, without waiting for an edge. After release, the full 7-cycle sequence repeats from 001.
- N=2, M=4, K=5:
  - COMPUTE lasts 9 cycles.
  - A_start_en[1] high on cnt 1..5.
  - B_start_en[3] high on cnt 3..7.
  - Each enable bit is high for exactly 5 cycles.
- Full 3x3 PE grid integration, A=[[1,2,3],[4,5,6],[7,8,9]], B=identity -> at C_write_en the PE C outputs equal A, e.g. C[1][2]=6 and C[2][0]=7.
